// File: rtl/rs_mult_pkg.sv
// rs_mult_pkg: shared sizing and FSM state encoding for the shift-add multiplier sequencer.
package rs_mult_pkg;
   localparam int N  = 6;
   localparam int PW = 2 * N;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPTURE} state_e;
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/rs_mult_sequencer.sv
// rs_mult_sequencer: serialises the multiplier LSB first into a shift-add datapath
// and captures the accumulator once N bits have been applied.
module rs_mult_sequencer
   import rs_mult_pkg::*;
#(
   parameter int N  = rs_mult_pkg::N,
   parameter int PW = rs_mult_pkg::PW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          x_bit,
   output logic [N-1:0]  y_out,
   output logic          load_out,
   input  logic [PW-1:0] p_in,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] product
);
   localparam int CW = cnt_width(N);
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic            done_q, done_d;
   logic            accept, last, cap;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      accept  = (state_q == IDLE) && start;
      last    = cnt_q == CW'(N - 1);
      cap     = state_q == CAPTURE;
      state_d = (state_q == IDLE)  ? (start ? LOAD : IDLE) :
                (state_q == LOAD)  ? SHIFT :
                (state_q == SHIFT) ? (last ? CAPTURE : SHIFT) : IDLE;
   end
   always_comb begin
      load_out = (state_q == IDLE) || (state_q == LOAD);
      busy     = state_q != IDLE;
      x_bit    = (state_q == SHIFT) & a_q[0];
      y_out    = b_q;
      done     = done_q;
      product  = prod_q;
   end
   // Operands are captured only on acceptance so later input changes cannot leak in.
   always_comb begin
      a_d    = accept ? a : (state_q == SHIFT) ? a_q >> 1 : a_q;
      b_d    = accept ? b : b_q;
      cnt_d  = (state_q == LOAD) ? '0 : (state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q;
      prod_d = cap ? p_in : prod_q;
      done_d = cap;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         prod_q <= prod_d;
         done_q <= done_d;
      end
endmodule

// File: tb/tb_rs_mult_sequencer.sv
// tb_rs_mult_sequencer: directed and random checks against a cycle-level reference model.
module tb_rs_mult_sequencer;
   localparam int N  = 6;
   localparam int PW = 12;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [N-1:0]  a = '0, b = '0;
   logic          x_bit, load_out, busy, done;
   logic [N-1:0]  y_out;
   logic [PW-1:0] p_in, product;
   int            n_cmp = 0, n_bad = 0;
   rs_mult_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .x_bit(x_bit), .y_out(y_out), .load_out(load_out), .p_in(p_in),
      .busy(busy), .done(done), .product(product)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // environment: serial shift-add multiplier fed by the sequencer
   int unsigned dp_acc;
   int          dp_k;
   always @(posedge clk)
      if (load_out) begin
         dp_acc <= 0;
         dp_k   <= 0;
      end else if (dp_k < N) begin
         if (x_bit) dp_acc <= dp_acc + (int'(y_out) << dp_k);
         dp_k <= dp_k + 1;
      end
   assign p_in = dp_acc[PW-1:0];
   // reference: ph = edges since acceptance (-1 idle); product is plain a*b of latched operands
   int            ph;
   logic [N-1:0]  ma, mb;
   logic [PW-1:0] m_prod;
   logic          m_done;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ph <= -1; ma <= '0; mb <= '0; m_prod <= '0; m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (ph < 0) begin
            if (start) begin ph <= 0; ma <= a; mb <= b; end
         end else if (ph == N + 1) begin
            ph <= -1; m_done <= 1'b1; m_prod <= PW'(int'(ma) * int'(mb));
         end else ph <= ph + 1;
      end
   function automatic logic exp_x();
      logic [N-1:0] t;
      t = ma;
      return (ph >= 1 && ph <= N) ? t[ph-1] : 1'b0;
   endfunction
   always @(negedge clk) begin
      chk("busy", busy, ph >= 0);
      chk("load_out", load_out, ph <= 0);
      chk("x_bit", x_bit, exp_x());
      chk("y_out", y_out, mb);
      chk("done", done, m_done);
      chk("product", product, m_prod);
   end
   // called at a falling edge; returns at the falling edge of the done cycle
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, output int nb, output logic [N-1:0] xs);
      int i;
      #1 a = ta; b = tb; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      nb = 0; xs = '0;
      for (i = 0; i < 20 && !done; i++) begin
         if (busy) begin
            if (nb >= 1 && nb <= N) xs[nb-1] = x_bit;
            nb++;
         end
         @(negedge clk);
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask
   int           nb, done_cnt;
   logic [N-1:0] xs;
   time          t1, t2;
   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_load", load_out, 1);
      chk("rst_x", x_bit, 0);
      chk("rst_done", done, 0);
      chk("rst_prod", product, 0);
      chk("rst_y", y_out, 0);
      @(negedge clk); @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_op(6'd3, 6'd5, nb, xs);
      chk("p3x5", product, 15);
      chk("busy8", nb, 8);
      chk("xseq3", xs, 6'b000011);
      run_op(6'd0, 6'd63, nb, xs);
      chk("p0x63", product, 0);
      chk("xseq0", xs, 0);
      chk("busy8b", nb, 8);
      run_op(6'd63, 6'd1, nb, xs);
      chk("p63x1", product, 63);
      t1 = $time;
      run_op(6'd1, 6'd63, nb, xs);
      t2 = $time;
      chk("p1x63", product, 63);
      chk("b2b_gap", 32'((t2 - t1) / 10), 9);
      // start held continuously with operands scrambled every cycle
      #1 start = 1'b1;
      done_cnt = 0; t1 = 0;
      for (int i = 0; i < 60 && done_cnt < 4; i++) begin
         @(negedge clk);
         if (done) begin
            if (done_cnt > 0) chk("held_gap", 32'(($time - t1) / 10), 9);
            t1 = $time;
            done_cnt++;
         end
         #1 a = N'($urandom); b = N'($urandom);
      end
      chk("held_results", done_cnt, 4);
      start = 1'b0;
      for (int i = 0; i < 12 && busy; i++) @(negedge clk);
      // reset during the third SHIFT cycle
      #1 a = 6'd45; b = 6'd27; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_load", load_out, 1);
      chk("abort_x", x_bit, 0);
      chk("abort_done", done, 0);
      chk("abort_prod", product, 0);
      @(negedge clk); @(negedge clk);
      #1 rst_n = 1'b1;
      chk("abort_nodone", done, 0);
      @(negedge clk);
      run_op(6'd2, 6'd7, nb, xs);
      chk("p2x7", product, 14);
      // random traffic: start pulses, holds and mid-operation operand churn
      for (int i = 0; i < 700; i++) begin
         #1 start = ($urandom_range(0, 3) == 0);
         a = N'($urandom); b = N'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
